// File: rtl/video_pkg.sv
// Shared constants for the scan doubler: output FSM encoding, sync polarity
// and default geometry parameters.
package video_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HSYNC  = 2'd1;
    localparam logic [1:0] ST_PIXELS = 2'd2;
    localparam logic [1:0] ST_BLANK  = 2'd3;

    // Level of videoSync during a sync pulse.
    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int DEPTH_DEFAULT        = 64;
    localparam int HSYNC_MIN_DEFAULT    = 8;
    localparam int VSYNC_MIN_DEFAULT    = 64;
    localparam int HSYNC_LEN_DEFAULT    = 4;
    localparam int COUNTER_BITS_DEFAULT = 12;

endpackage

// File: rtl/line_buffer_ram.sv
// Two-bank 1-bit line buffer: synchronous write, registered read,
// address = {bank, index}.
module line_buffer_ram
    import video_pkg::*;
#(
    parameter int depth = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(depth):0]   wr_addr,
    input  logic                     wr_data,
    input  logic [$clog2(depth):0]   rd_addr,
    output logic                     rd_data
);

    logic mem [0:2*depth-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/video_scan_doubler.sv
// Captures each incoming scanline into one bank of a line buffer and replays
// the previous line twice per input line with regenerated VGA sync.
module video_scan_doubler
    import video_pkg::*;
#(
    parameter int depth       = DEPTH_DEFAULT,
    parameter int hsyncMin    = HSYNC_MIN_DEFAULT,
    parameter int vsyncMin    = VSYNC_MIN_DEFAULT,
    parameter int hsyncLen    = HSYNC_LEN_DEFAULT,
    parameter int counterBits = COUNTER_BITS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   videoSync,
    input  logic                   videoPixel,
    output logic                   vgaHsync,
    output logic                   vgaVsync,
    output logic                   vgaPixel,
    output logic [$clog2(depth):0] lineLength
);

    localparam int IW = $clog2(depth);
    localparam int CW = counterBits;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [IW:0]   FULL    = (IW+1)'(depth);

    logic [CW-1:0] low_count;
    logic [CW-1:0] period_count;
    logic [CW-1:0] half_period;
    logic [CW-1:0] out_count;
    logic          write_bank;
    logic          phase;
    logic [IW:0]   write_addr;
    logic [1:0]    state;
    logic          rep2;
    logic [IW:0]   rd_idx;
    logic          vld_p1;
    logic          rd_data;

    logic          in_sync;
    logic          line_start;
    logic          half_match;
    logic          restart;
    logic          write_en;
    logic          wr_bank;
    logic [IW:0]   write_idx;
    logic [IW:0]   wr_addr;
    logic [IW:0]   rd_addr;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // A line start is the first active clk after a long-enough sync run;
    // the bank swap and the first pixel write happen on that same clk.
    always_comb begin
        in_sync    = (videoSync == SYNC_ACTIVE);
        line_start = !in_sync && (low_count >= CW'(hsyncMin));
        half_match = !rep2 && (state != ST_IDLE) && (half_period != '0)
                     && (out_count == half_period - 1'b1);
        restart    = line_start || half_match;
        write_idx  = line_start ? '0 : write_addr;
        wr_bank    = line_start ? ~write_bank : write_bank;
        write_en   = !in_sync && (line_start || !phase) && (write_idx < FULL);
        wr_addr    = {wr_bank, write_idx[IW-1:0]};
        rd_addr    = {~write_bank, rd_idx[IW-1:0]};
    end

    line_buffer_ram #(.depth(depth)) u_ram (
        .clk     (clk),
        .wr_en   (write_en),
        .wr_addr (wr_addr),
        .wr_data (videoPixel),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Input side: sync measurement and line capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            low_count    <= '0;
            period_count <= '0;
            half_period  <= '0;
            write_bank   <= 1'b0;
            write_addr   <= '0;
            phase        <= 1'b0;
            lineLength   <= '0;
            vgaVsync     <= 1'b0;
        end else begin
            low_count    <= in_sync ? sat_inc(low_count) : '0;
            vgaVsync     <= in_sync && (low_count >= CW'(vsyncMin));
            period_count <= line_start ? '0 : sat_inc(period_count);
            if (line_start) begin
                write_bank  <= ~write_bank;
                lineLength  <= write_addr;
                half_period <= sat_inc(period_count) >> 1;
            end
            if (!in_sync) begin
                phase <= line_start ? 1'b1 : ~phase;
            end
            if (write_en) begin
                write_addr <= write_idx + 1'b1;
            end else if (line_start) begin
                write_addr <= '0;
            end
        end
    end

    // Output side: read issue, then RAM register (p1), then vgaPixel register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rep2      <= 1'b0;
            out_count <= '0;
            rd_idx    <= '0;
            vld_p1    <= 1'b0;
            vgaHsync  <= 1'b0;
            vgaPixel  <= 1'b0;
        end else begin
            out_count <= restart ? '0 : sat_inc(out_count);
            vld_p1    <= !restart && (state == ST_PIXELS);
            vgaPixel  <= !restart && vld_p1 && rd_data;
            if (restart) begin
                state    <= ST_HSYNC;
                rep2     <= !line_start;
                vgaHsync <= 1'b1;
                rd_idx   <= '0;
            end else begin
                case (state)
                    ST_HSYNC: begin
                        if (out_count == CW'(hsyncLen - 1)) begin
                            vgaHsync <= 1'b0;
                            rd_idx   <= '0;
                            state    <= (lineLength == '0) ? ST_BLANK : ST_PIXELS;
                        end
                    end
                    ST_PIXELS: begin
                        if (rd_idx == lineLength - 1'b1) begin
                            state <= ST_BLANK;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_scan_doubler.sv
// Scoreboard bench for video_scan_doubler: stimulus pushes per-clk expected
// outputs, a negedge monitor pops and compares them.
module tb_video_scan_doubler;

    logic       clk = 1'b0;
    logic       reset;
    logic       videoSync;
    logic       videoPixel;
    logic       vgaHsync;
    logic       vgaVsync;
    logic       vgaPixel;
    logic [6:0] lineLength;

    video_scan_doubler dut (
        .clk        (clk),
        .reset      (reset),
        .videoSync  (videoSync),
        .videoPixel (videoPixel),
        .vgaHsync   (vgaHsync),
        .vgaVsync   (vgaVsync),
        .vgaPixel   (vgaPixel),
        .lineLength (lineLength)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic       hs;
        logic       vs;
        logic       px;
        logic [6:0] len;
        string      nm;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] pat_a, pat_b, pat_c;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at < cyc) begin
            mon_e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s @%0d: expectation never checked (now %0d)", mon_e.nm, mon_e.at, cyc);
        end
        if (q.size() > 0 && q[0].at == cyc) begin
            mon_e = q.pop_front();
            n_cmp++;
            if ({vgaHsync, vgaVsync, vgaPixel, lineLength} !== {mon_e.hs, mon_e.vs, mon_e.px, mon_e.len}) begin
                n_bad++;
                $display("FAIL %s @%0d: hs/vs/px/len got %b/%b/%b/%0d want %b/%b/%b/%0d",
                         mon_e.nm, mon_e.at, vgaHsync, vgaVsync, vgaPixel, lineLength,
                         mon_e.hs, mon_e.vs, mon_e.px, mon_e.len);
            end
        end
    end

    task automatic drive(input logic r, input logic s, input logic p);
        reset = r;
        videoSync = s;
        videoPixel = p;
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle(input int e0, input int span, input string nm);
        exp_t e;
        for (int k = 0; k < span; k++) begin
            e.at = e0 + k; e.hs = 1'b0; e.vs = 1'b0; e.px = 1'b0; e.len = '0; e.nm = nm;
            q.push_back(e);
        end
    endtask

    // Replay timing: hsync for 4 clk from the rise, pixel i at rise+6+i,
    // second repetition restarts at rise+half.
    task automatic push_window(input int e0, input int span, input int n, input int half,
                               input logic [63:0] pix, input int len,
                               input int vs_lo, input int vs_hi, input string nm);
        exp_t e;
        int   r;
        for (int k = 0; k < span; k++) begin
            r = (k >= half) ? k - half : k;
            e.at  = e0 + k;
            e.hs  = (r < 4);
            e.px  = 1'b0;
            if (r >= 6 && r - 6 < n) e.px = pix[r-6];
            e.vs  = (e0 + k >= vs_lo) && (e0 + k <= vs_hi);
            e.len = 7'(len);
            e.nm  = nm;
            q.push_back(e);
        end
    endtask

    initial begin
        reset = 1'b1;
        videoSync = 1'b0;
        videoPixel = 1'b0;
        pat_a = '0;
        pat_c = '0;
        for (int i = 0; i < 10; i++) pat_a[i] = (i % 2 == 0);
        pat_b = 64'h1CB;
        for (int i = 0; i < 64; i++) pat_c[i] = (i % 3 == 0);

        push_idle(1, 3, "reset");
        repeat (3) drive(1, 0, 0);
        push_idle(cyc + 1, 10, "post_reset");
        repeat (10) drive(0, 0, 0);

        // Line A capture; replay of the empty line captured since reset.
        push_window(cyc + 1, 30, 0, 5, '0, 0, -1, -1, "blank_first");
        for (int i = 0; i < 20; i++) drive(0, 1, pat_a[i/2]);
        repeat (10) drive(0, 0, 0);

        // Line B capture with a 5 clk glitch; replay of line A.
        push_window(cyc + 1, 35, 10, 15, pat_a, 10, -1, -1, "line_a");
        for (int i = 0; i < 10; i++) drive(0, 1, pat_b[i/2]);
        repeat (5) drive(0, 0, 1);
        for (int i = 0; i < 10; i++) drive(0, 1, pat_b[5 + i/2]);
        repeat (10) drive(0, 0, 0);

        // Line C (75 slots, truncated) then a 70 clk vsync pulse; replay of line B.
        push_window(cyc + 1, 220, 10, 17, pat_b, 10, cyc + 1 + 214, cyc + 1 + 219, "line_b_vsync");
        for (int i = 0; i < 150; i++) drive(0, 1, (i/2 < 64) ? pat_c[i/2] : 1'b0);
        repeat (70) drive(0, 0, 0);

        // Line D all lit; replay of truncated line C.
        push_window(cyc + 1, 200, 64, 110, pat_c, 64, -1, -1, "line_c_trunc");
        repeat (190) drive(0, 1, 1);
        repeat (10) drive(0, 0, 0);

        // Replay of line D interrupted by reset while in PIXELS.
        push_window(cyc + 1, 11, 64, 100, '1, 64, -1, -1, "line_d");
        repeat (11) drive(0, 1, 1);
        push_idle(cyc + 1, 2, "midline_reset");
        repeat (2) drive(1, 0, 0);
        push_idle(cyc + 1, 10, "after_reset");
        repeat (10) drive(0, 0, 0);
        push_window(cyc + 1, 20, 0, 5, '0, 0, -1, -1, "blank_after_reset");
        repeat (20) drive(0, 1, 1);

        for (int i = 0; i < 50 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d, want completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
